// File: rtl/seg_pkg.sv
`timescale 1ns/1ps
// Shared constants and the scan FSM state type for the seven-segment display path.
package seg_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned SEG_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/seg7.sv
`timescale 1ns/1ps
// Hex-to-seven-segment decoder; segments = {g,f,e,d,c,b,a}, active-high.
module seg7
  import seg_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [SEG_W-1:0] segments
);

  always_comb begin
    segments = '0;
    case (bcd)
      4'h0: segments = 7'h3F;
      4'h1: segments = 7'h06;
      4'h2: segments = 7'h5B;
      4'h3: segments = 7'h4F;
      4'h4: segments = 7'h66;
      4'h5: segments = 7'h6D;
      4'h6: segments = 7'h7D;
      4'h7: segments = 7'h07;
      4'h8: segments = 7'h7F;
      4'h9: segments = 7'h6F;
      4'hA: segments = 7'h77;
      4'hB: segments = 7'h7C;
      4'hC: segments = 7'h39;
      4'hD: segments = 7'h5E;
      4'hE: segments = 7'h79;
      4'hF: segments = 7'h71;
      default: segments = '0;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
`timescale 1ns/1ps
// Time-multiplexed scan controller for NUM_DIGITS seven-segment digits with
// blanking gaps, tear-free shadow update, leading-zero suppression and blink.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DIGIT_CYCLES = 10000,
  parameter int unsigned BLANK_CYCLES = 200
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [BCD_W*NUM_DIGITS-1:0]   digits_in,
  input  logic                          load,
  input  logic                          lz_en,
  input  logic [NUM_DIGITS-1:0]         blink_mask,
  input  logic                          blink_tick,
  output logic [SEG_W-1:0]              segments,
  output logic [NUM_DIGITS-1:0]         digit_en,
  output logic                          frame_done
);

  localparam int unsigned CNT_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             start, frame_wrap;

  logic [BCD_W*NUM_DIGITS-1:0] stage_q, shadow_q;
  logic                        load_pending_q;
  logic                        blink_phase_q;
  logic                        copy;

  logic [BCD_W-1:0]      cur_digit;
  logic [SEG_W-1:0]      seg_raw;
  logic [NUM_DIGITS-1:0] supp_mask;
  logic                  blanked;

  logic [SEG_W-1:0]      segments_d;
  logic [NUM_DIGITS-1:0] digit_en_d;
  logic                  frame_done_d;

  // A digit is suppressed when it and every higher digit are zero; digit 0 never is.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [BCD_W*NUM_DIGITS-1:0] v);
    logic zero_above;
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int unsigned i = NUM_DIGITS; i > 0; i--) begin
      zero_above = zero_above && (v[(i-1)*BCD_W +: BCD_W] == '0);
      if (i > 1) lz_mask[i-1] = zero_above;
    end
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_d != state_q)
        cnt_q <= '0;
      else if (state_q != ST_IDLE)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  // Every phase end is a state change, so the counter is cleared before it can wrap.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    start      = 1'b0;
    frame_wrap = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (enable) begin
          state_d = ST_BLANK;
          start   = 1'b1;
        end
      end
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          if (enable) begin
            state_d = ST_DRIVE;
          end else begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end
        end
      end
      ST_DRIVE: begin
        if (cnt_q == DRIVE_LAST) begin
          if (idx_q == IDX_LAST) begin
            idx_d      = '0;
            frame_wrap = 1'b1;
            state_d    = enable ? ST_BLANK : ST_IDLE;
          end else if (enable) begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_BLANK;
          end else begin
            idx_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Coincident load and copy: the copy takes the old staging value, the new one stays pending.
  assign copy = load_pending_q && (start || frame_wrap);

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q        <= '0;
      shadow_q       <= '0;
      load_pending_q <= 1'b0;
      blink_phase_q  <= 1'b0;
    end else begin
      if (load) stage_q <= digits_in;
      if (copy) shadow_q <= stage_q;
      if (load)
        load_pending_q <= 1'b1;
      else if (copy)
        load_pending_q <= 1'b0;
      if (blink_tick) blink_phase_q <= ~blink_phase_q;
    end
  end

  always_comb begin
    cur_digit = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) cur_digit = shadow_q[i*BCD_W +: BCD_W];
    end
  end

  seg7 u_seg7 (
    .bcd      (cur_digit),
    .segments (seg_raw)
  );

  assign supp_mask = lz_mask(shadow_q);
  assign blanked   = (lz_en && supp_mask[idx_q]) || (blink_mask[idx_q] && blink_phase_q);

  // Outputs are computed from the next state so the registered pins line up with the FSM.
  always_comb begin
    digit_en_d   = '0;
    segments_d   = '0;
    frame_done_d = frame_wrap;
    if (state_d == ST_DRIVE) begin
      digit_en_d = NUM_DIGITS'(1) << idx_q;
      segments_d = blanked ? '0 : seg_raw;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      segments   <= '0;
      digit_en   <= '0;
      frame_done <= 1'b0;
    end else begin
      segments   <= segments_d;
      digit_en   <= digit_en_d;
      frame_done <= frame_done_d;
    end
  end

endmodule
